xor_path_sequencer: RTL and testbench
=====================================

# xor_path_sequencer

Sequencer that drives a two-input XOR path-delay cell through all four input combinations. For each step it measures, in clock cycles, how long the cell's output takes to reach the expected value. It sits beside a `foo`-style specify-annotated cell as its stimulus/measurement controller and reports one result per step, plus a run summary. Runs are launched by a single `start` pulse and can be aborted at any time.

## Interface
- Clock/reset (already decided): one clock; reset is synchronous and active-high.
- `CNT_W`, default 8: width of the cycle counter and of the measurement outputs.
- `SETTLE_MAX`, default 200: timeout in cycles per step; must be < 2^`CNT_W`.
- `HOLD`, default 4: idle cycles after each report before the next step; 0 allowed.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  cancel a run; has priority over everything except `rst`.
- `x_in`  in  1  output of the cell under test; sampled raw every edge.
- `a_out`, `b_out`  out  1 each  drive the cell inputs.
- `busy`  out  1  high in every state except IDLE.
- `meas_valid`  out  1  one-cycle pulse per completed step.
- `meas_idx`  out  2  step index {a,b} for the current report.
- `meas_cycles`  out  `CNT_W`  settle latency for the step.
- `meas_timeout`  out  1  the reported step timed out; qualified by `meas_valid`.
- `done`  out  1  one-cycle pulse at the end of a full, un-aborted run.
- `max_cycles`  out  `CNT_W`  largest `meas_cycles` seen this run.
- `timeout_cnt`  out  3  number of timed-out steps this run (0..4).

## Operation
- **States:** IDLE, WAIT, REPORT, HOLDS, DONE.
- **IDLE**
  - On `start`=1: go to WAIT with `idx`=0, `{a_out,b_out}`=00, `cnt`=0, `max_cycles`=0, `timeout_cnt`=0.
  - `start` is ignored in any other state.
- **WAIT**, evaluated every edge; expected value = `a_out ^ b_out`:
  - `x_in`==expected → REPORT; `meas_cycles`=`cnt`, `meas_timeout`=0.
  - otherwise, `cnt`==`SETTLE_MAX` → REPORT; `meas_cycles`=`SETTLE_MAX`, `meas_timeout`=1, `timeout_cnt`+1.
  - otherwise `cnt`+1.
- **REPORT**
  - `meas_valid`=1 for exactly this cycle; `meas_idx`=`idx`.
  - `max_cycles` is updated if `meas_cycles` is larger. The update is visible from the next cycle.
  - Go to HOLDS, or straight to the next step / DONE when `HOLD`=0.
- **HOLDS**
  - Counts `HOLD` cycles with `a_out`/`b_out` unchanged.
  - Then: if `idx`==3 → DONE; else `idx`+1, `{a_out,b_out}`=`idx`+1, `cnt`=0, → WAIT.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
  - `a_out`/`b_out` keep their last values (11).
  - `max_cycles` and `timeout_cnt` hold until the next `start`.
- **Abort**
  - `abort`=1 in any non-IDLE state → IDLE on the next edge.
  - No `meas_valid`, no `done`.
  - `a_out`/`b_out` and the summary outputs hold their values.
- **Step order** is fixed: 00, 01, 10, 11. Expected x per step: 0, 1, 1, 0.
- The counter never wraps: it saturates at `SETTLE_MAX` via the timeout rule.

## Timing
- **Reset values:** all outputs 0, state IDLE. Reset mid-run behaves like abort, except all outputs clear to 0.
- **Start latency:** `start` high at edge E → `busy`=1 and step-0 drive valid after E.
- **Drive:** step inputs change at edge E0, the edge entering WAIT.
- **Latency definition:** if the cell output reflects the new value from edge E0+D, the first matching sample is at E0+D+1 and `meas_cycles`=D.
- **Immediate match:** a step whose expected x is unchanged reports 0.
- **REPORT** is the cycle after the matching edge. `meas_*` fields stay stable until the next REPORT.
- **Run length:** minimum run is 4×(D+2+`HOLD`) cycles + DONE.
- **Simultaneous events:**
  - `abort` with a match or timeout: abort wins and nothing is reported.
  - `start` with `abort` in IDLE: start is taken.

## Test plan
- **Nominal:** responder copies `a_out^b_out` to `x_in` 3 cycles late, `HOLD`=4, pulse `start`.
  - Reports idx0=0, idx1=3, idx2=0, idx3=3.
  - `max_cycles`=3, `timeout_cnt`=0, one `done`, final `a_out`/`b_out`=1/1.
- **Timeout:** `x_in` stuck at 0, `SETTLE_MAX`=10.
  - idx1 and idx2 report 10 with `meas_timeout`=1; idx0 and idx3 report 0.
  - `timeout_cnt`=2.
- **Abort:** assert `abort` while in WAIT of idx2.
  - No further `meas_valid`, no `done`, `busy`=0 on the next cycle, `a_out`/`b_out`=1/0.
- **Start ignored while busy / restart:**
  - `start` pulses during a run have no effect.
  - A new `start` after DONE clears `max_cycles`/`timeout_cnt` and re-runs from 00.
- **Zero hold:** `HOLD`=0, responder delay 0.
  - All reports 0; `meas_valid` spacing exactly 2 cycles.
- **Reset mid-run:** assert `rst` in REPORT.
  - Next cycle all outputs are 0 and the state is IDLE; a following `start` produces a normal run.

Source files
------------

// File: rtl/xor_path_sequencer.sv
// Stimulus/measurement controller for a two-input XOR path-delay cell: steps the
// inputs through 00,01,10,11 and reports how many cycles the output takes to settle.
module xor_path_sequencer #(
    parameter int CNT_W      = 8,
    parameter int SETTLE_MAX = 200,
    parameter int HOLD       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             x_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             meas_valid,
    output logic [1:0]       meas_idx,
    output logic [CNT_W-1:0] meas_cycles,
    output logic             meas_timeout,
    output logic             done,
    output logic [CNT_W-1:0] max_cycles,
    output logic [2:0]       timeout_cnt
);

    localparam int                HOLD_W     = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((HOLD > 0) ? HOLD - 1 : 0);
    localparam logic [CNT_W-1:0]  SETTLE_LIM = CNT_W'(SETTLE_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REPORT,
        S_HOLDS,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [1:0]        idx_q;          // step index; also the {a,b} drive pattern
    logic [CNT_W-1:0]  cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic              meas_valid_q;
    logic [1:0]        meas_idx_q;
    logic [CNT_W-1:0]  meas_cycles_q;
    logic              meas_timeout_q;
    logic              done_q;
    logic [CNT_W-1:0]  max_q;
    logic [2:0]        timeout_cnt_q;

    logic              match_d;
    logic [1:0]        idx_d;
    logic [CNT_W-1:0]  max_d;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        match_d = (x_in == (idx_q[1] ^ idx_q[0]));
        idx_d   = idx_q + 2'd1;
        max_d   = (meas_cycles_q > max_q) ? meas_cycles_q : max_q;
    end

    // NOTE: state is updated with non-blocking assignments only, and reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            hold_q         <= '0;
            meas_valid_q   <= 1'b0;
            meas_idx_q     <= '0;
            meas_cycles_q  <= '0;
            meas_timeout_q <= 1'b0;
            done_q         <= 1'b0;
            max_q          <= '0;
            timeout_cnt_q  <= '0;
        end else if (abort && state_q != S_IDLE) begin
            // Abort leaves drive and summary values as they were.
            state_q      <= S_IDLE;
            meas_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q       <= S_WAIT;
                        idx_q         <= '0;
                        cnt_q         <= '0;
                        max_q         <= '0;
                        timeout_cnt_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (match_d) begin
                        state_q        <= S_REPORT;
                        meas_valid_q   <= 1'b1;
                        meas_idx_q     <= idx_q;
                        meas_cycles_q  <= cnt_q;
                        meas_timeout_q <= 1'b0;
                    end else if (cnt_q == SETTLE_LIM) begin
                        state_q        <= S_REPORT;
                        meas_valid_q   <= 1'b1;
                        meas_idx_q     <= idx_q;
                        meas_cycles_q  <= SETTLE_LIM;
                        meas_timeout_q <= 1'b1;
                        timeout_cnt_q  <= timeout_cnt_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_REPORT: begin
                    meas_valid_q <= 1'b0;
                    max_q        <= max_d;
                    if (HOLD != 0) begin
                        hold_q  <= '0;
                        state_q <= S_HOLDS;
                    end else if (idx_q == 2'd3) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_d;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_HOLDS: begin
                    if (hold_q != HOLD_LAST) begin
                        hold_q <= hold_q + 1'b1;
                    end else if (idx_q == 2'd3) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_d;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_out        = idx_q[1];
    assign b_out        = idx_q[0];
    assign busy         = (state_q != S_IDLE);
    assign meas_valid   = meas_valid_q;
    assign meas_idx     = meas_idx_q;
    assign meas_cycles  = meas_cycles_q;
    assign meas_timeout = meas_timeout_q;
    assign done         = done_q;
    assign max_cycles   = max_q;
    assign timeout_cnt  = timeout_cnt_q;

endmodule

// File: tb/tb_xor_path_sequencer.sv
// Directed bench: one sequencer with a 3-cycle (or stuck-at-0) responder and HOLD=4,
// and one with a zero-delay responder and HOLD=0.
module tb_xor_path_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Unit 1: HOLD=4, SETTLE_MAX=10
    logic       start1 = 1'b0, abort1 = 1'b0, stuck = 1'b0;
    logic       x1, a1, b1, busy1, mv1, mto1, done1;
    logic [1:0] midx1;
    logic [7:0] mcyc1, max1;
    logic [2:0] tcnt1;
    logic [2:0] pipe1 = '0;

    // Unit z: HOLD=0, SETTLE_MAX=10
    logic       start_z = 1'b0, abort_z = 1'b0;
    logic       x_z, a_z, b_z, busy_z, mv_z, mto_z, done_z;
    logic [1:0] midx_z;
    logic [7:0] mcyc_z, max_z;
    logic [2:0] tcnt_z;

    int errors = 0, checks = 0;
    int valid_cnt1 = 0, done_cnt1 = 0;
    int cyc = 0;

    xor_path_sequencer #(.CNT_W(8), .SETTLE_MAX(10), .HOLD(4)) dut (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .x_in(x1),
        .a_out(a1), .b_out(b1), .busy(busy1), .meas_valid(mv1), .meas_idx(midx1),
        .meas_cycles(mcyc1), .meas_timeout(mto1), .done(done1),
        .max_cycles(max1), .timeout_cnt(tcnt1)
    );

    xor_path_sequencer #(.CNT_W(8), .SETTLE_MAX(10), .HOLD(0)) dut_z (
        .clk(clk), .rst(rst), .start(start_z), .abort(abort_z), .x_in(x_z),
        .a_out(a_z), .b_out(b_z), .busy(busy_z), .meas_valid(mv_z), .meas_idx(midx_z),
        .meas_cycles(mcyc_z), .meas_timeout(mto_z), .done(done_z),
        .max_cycles(max_z), .timeout_cnt(tcnt_z)
    );

    // Cell models: unit 1 sees a^b three edges late, unit z sees it immediately.
    always @(posedge clk) pipe1 <= {pipe1[1:0], a1 ^ b1};
    assign x1  = stuck ? 1'b0 : pipe1[2];
    assign x_z = a_z ^ b_z;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mv1)   valid_cnt1++;
        if (done1) done_cnt1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for meas_valid or done on the chosen unit, sampled at negedge.
    task automatic wait_for(input bit z, input bit want_done, input string tag);
        bit ok = 1'b0;
        int n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            n++;
            if (want_done) ok = z ? done_z : done1;
            else           ok = z ? mv_z   : mv1;
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL %s: observed no pulse expected one within 100 cycles", tag);
        end
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    int nom_cyc[4] = '{0, 3, 0, 3};
    int to_cyc[4]  = '{0, 10, 10, 0};
    int to_flag[4] = '{0, 1, 1, 0};
    int vc, dc, prev_cyc;
    bit found;

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_valid", mv1, 0);
        check("rst_ab", {a1, b1}, 0);
        check("rst_max", max1, 0);
        check("rst_tcnt", tcnt1, 0);
        check("rst_done", done1, 0);

        // Nominal run with a start pulse injected mid-run
        pulse_start1();
        check("start_busy", busy1, 1);
        check("start_ab", {a1, b1}, 0);
        for (int k = 0; k < 4; k++) begin
            wait_for(0, 0, "nom_valid");
            check("nom_idx", midx1, k);
            check("nom_cycles", mcyc1, nom_cyc[k]);
            check("nom_timeout", mto1, 0);
            if (k == 0) pulse_start1();
            if (k == 1) begin
                check("nom_max_before", max1, 0);
                @(negedge clk);
                check("nom_max_after", max1, 3);
            end
        end
        wait_for(0, 1, "nom_done");
        check("nom_max", max1, 3);
        check("nom_tcnt", tcnt1, 0);
        check("nom_ab", {a1, b1}, 2'b11);
        @(negedge clk);
        check("nom_idle", busy1, 0);
        check("nom_done_pulse", done1, 0);
        check("nom_done_cnt", done_cnt1, 1);
        check("nom_valid_cnt", valid_cnt1, 4);

        // Timeout run (restart clears the summary)
        stuck = 1'b1;
        pulse_start1();
        check("restart_max", max1, 0);
        check("restart_tcnt", tcnt1, 0);
        for (int k = 0; k < 4; k++) begin
            wait_for(0, 0, "to_valid");
            check("to_idx", midx1, k);
            check("to_cycles", mcyc1, to_cyc[k]);
            check("to_timeout", mto1, to_flag[k]);
        end
        wait_for(0, 1, "to_done");
        check("to_tcnt", tcnt1, 2);
        check("to_max", max1, 10);
        stuck = 1'b0;
        repeat (4) @(negedge clk);

        // Abort in WAIT of idx2, on the same edge the match would occur
        pulse_start1();
        wait_for(0, 0, "ab_valid0");
        wait_for(0, 0, "ab_valid1");
        check("ab_idx1_cycles", mcyc1, 3);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            found = a1 && !b1;
        end
        check("ab_reach_idx2", found, 1);
        vc = valid_cnt1;
        dc = done_cnt1;
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check("ab_busy", busy1, 0);
        check("ab_ab", {a1, b1}, 2'b10);
        check("ab_meas_idx", midx1, 1);
        check("ab_max", max1, 3);
        repeat (30) @(negedge clk);
        check("ab_no_valid", valid_cnt1, vc);
        check("ab_no_done", done_cnt1, dc);

        // Zero hold, zero delay
        start_z = 1'b1;
        @(negedge clk);
        start_z = 1'b0;
        prev_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_for(1, 0, "zh_valid");
            check("zh_idx", midx_z, k);
            check("zh_cycles", mcyc_z, 0);
            if (k > 0) check("zh_spacing", cyc - prev_cyc, 2);
            prev_cyc = cyc;
        end
        wait_for(1, 1, "zh_done");
        check("zh_ab", {a_z, b_z}, 2'b11);

        // Reset in REPORT of idx1, then a normal run
        repeat (4) @(negedge clk);
        pulse_start1();
        wait_for(0, 0, "rr_valid0");
        wait_for(0, 0, "rr_valid1");
        check("rr_pre_cycles", mcyc1, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_busy", busy1, 0);
        check("rr_valid", mv1, 0);
        check("rr_meas", {midx1, mcyc1, mto1}, 0);
        check("rr_done", done1, 0);
        check("rr_summary", {max1, tcnt1}, 0);
        check("rr_ab", {a1, b1}, 0);
        repeat (5) @(negedge clk);
        vc = valid_cnt1;
        pulse_start1();
        for (int k = 0; k < 4; k++) begin
            wait_for(0, 0, "rr_run_valid");
            check("rr_run_idx", midx1, k);
            check("rr_run_cycles", mcyc1, nom_cyc[k]);
        end
        wait_for(0, 1, "rr_run_done");
        check("rr_run_max", max1, 3);
        check("rr_run_valid_cnt", valid_cnt1 - vc, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
